// File: rtl/dbus_pkg.sv
// Shared types and constants for the data-bus Wishbone master.
// Holds the FSM state encoding and the RISC-V load/store funct3 codes.
package dbus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } dbus_state_t;

   localparam logic [2:0] MEM_B  = 3'b000;
   localparam logic [2:0] MEM_H  = 3'b001;
   localparam logic [2:0] MEM_W  = 3'b010;
   localparam logic [2:0] MEM_BU = 3'b100;
   localparam logic [2:0] MEM_HU = 3'b101;

endpackage

// File: rtl/dbus_lane_align.sv
// Byte-lane steering between the core's LSB-aligned data and the 32-bit bus.
// Request side: select mask, store replication, alignment/opcode checks. Response side: load extract/extend.
module dbus_lane_align
   import dbus_pkg::*;
(
   input  logic [2:0]  req_op_i,
   input  logic [1:0]  req_off_i,
   input  logic [31:0] wdata_i,
   output logic [3:0]  sel_o,
   output logic [31:0] dat_o,
   output logic        misaligned_o,
   output logic        undefined_o,
   input  logic [2:0]  rsp_op_i,
   input  logic [1:0]  rsp_off_i,
   input  logic [31:0] bus_dat_i,
   output logic [31:0] rdata_o
);

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   always_comb begin
      sel_o        = 4'b0000;
      dat_o        = wdata_i;
      misaligned_o = 1'b0;
      undefined_o  = 1'b0;
      case (req_op_i)
         MEM_B, MEM_BU: begin
            sel_o = 4'b0001 << req_off_i;
            dat_o = {4{wdata_i[7:0]}};
         end
         MEM_H, MEM_HU: begin
            sel_o        = 4'b0011 << req_off_i;
            dat_o        = {2{wdata_i[15:0]}};
            misaligned_o = req_off_i[0];
         end
         MEM_W: begin
            sel_o        = 4'b1111;
            misaligned_o = (req_off_i != 2'b00);
         end
         default: undefined_o = 1'b1;
      endcase
   end

   // Halfword lanes only ever sit at offset 0 or 2, so offset bit 1 picks the half.
   always_comb begin
      rd_byte = bus_dat_i[7:0];
      case (rsp_off_i)
         2'd0: rd_byte = bus_dat_i[7:0];
         2'd1: rd_byte = bus_dat_i[15:8];
         2'd2: rd_byte = bus_dat_i[23:16];
         2'd3: rd_byte = bus_dat_i[31:24];
         default: rd_byte = bus_dat_i[7:0];
      endcase
      rd_half = rsp_off_i[1] ? bus_dat_i[31:16] : bus_dat_i[15:0];
      case (rsp_op_i)
         MEM_B:   rdata_o = {{24{rd_byte[7]}}, rd_byte};
         MEM_BU:  rdata_o = {24'd0, rd_byte};
         MEM_H:   rdata_o = {{16{rd_half[15]}}, rd_half};
         MEM_HU:  rdata_o = {16'd0, rd_half};
         MEM_W:   rdata_o = bus_dat_i;
         default: rdata_o = 32'd0;
      endcase
   end

endmodule

// File: rtl/dbus_wb_master.sv
// Data-bus bridge from the core MEM stage to a classic single-beat Wishbone master.
// Each access walks IDLE -> REQ -> RESP; faults skip REQ and answer in RESP directly.
module dbus_wb_master
   import dbus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_wdata_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [2:0]  mem_op_i,
   output logic [31:0] mem_rdata_o,
   output logic        mem_ack_o,
   output logic        stall_o,
   output logic        bus_err_o,
   output logic        misaligned_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i
);

   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   dbus_state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic        cyc_q, cyc_d;
   logic        we_q, we_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic [3:0]  sel_q, sel_d;
   logic [2:0]  op_q, op_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;
   logic        mis_q, mis_d;

   logic [3:0]  lane_sel;
   logic [31:0] lane_dat;
   logic [31:0] lane_rdata;
   logic        lane_mis;
   logic        lane_undef;
   logic        req_any;

   dbus_lane_align u_lane (
      .req_op_i     (mem_op_i),
      .req_off_i    (mem_addr_i[1:0]),
      .wdata_i      (mem_wdata_i),
      .sel_o        (lane_sel),
      .dat_o        (lane_dat),
      .misaligned_o (lane_mis),
      .undefined_o  (lane_undef),
      .rsp_op_i     (op_q),
      .rsp_off_i    (off_q),
      .bus_dat_i    (wb_dat_i),
      .rdata_o      (lane_rdata)
   );

   assign req_any = mem_read_i | mem_write_i;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cyc_d   = cyc_q;
      we_d    = we_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      sel_d   = sel_q;
      op_d    = op_q;
      off_d   = off_q;
      rdata_d = rdata_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      mis_d   = 1'b0;
      stall_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_any) begin
               stall_o = 1'b1;
               if (lane_undef || lane_mis) begin
                  state_d = ST_RESP;
                  ack_d   = 1'b1;
                  err_d   = lane_undef;
                  mis_d   = ~lane_undef;
                  rdata_d = 32'd0;
               end else begin
                  state_d = ST_REQ;
                  cyc_d   = 1'b1;
                  cnt_d   = '0;
                  we_d    = mem_write_i;
                  adr_d   = {mem_addr_i[31:2], 2'b00};
                  dat_d   = lane_dat;
                  sel_d   = lane_sel;
                  op_d    = mem_op_i;
                  off_d   = mem_addr_i[1:0];
               end
            end
         end
         ST_REQ: begin
            stall_o = 1'b1;
            // Error takes priority over a simultaneous ack; the timeout behaves like an error.
            if (wb_err_i || (!wb_ack_i && cnt_q == CNT_LAST)) begin
               state_d = ST_RESP;
               cyc_d   = 1'b0;
               ack_d   = 1'b1;
               err_d   = 1'b1;
               rdata_d = 32'd0;
            end else if (wb_ack_i) begin
               state_d = ST_RESP;
               cyc_d   = 1'b0;
               ack_d   = 1'b1;
               rdata_d = we_q ? 32'd0 : lane_rdata;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cyc_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= 32'd0;
         dat_q   <= 32'd0;
         sel_q   <= 4'd0;
         op_q    <= 3'd0;
         off_q   <= 2'd0;
         rdata_q <= 32'd0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cyc_q   <= cyc_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         sel_q   <= sel_d;
         op_q    <= op_d;
         off_q   <= off_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         mis_q   <= mis_d;
      end
   end

   assign wb_cyc_o     = cyc_q;
   assign wb_stb_o     = cyc_q;
   assign wb_we_o      = we_q;
   assign wb_adr_o     = adr_q;
   assign wb_dat_o     = dat_q;
   assign wb_sel_o     = sel_q;
   assign mem_rdata_o  = rdata_q;
   assign mem_ack_o    = ack_q;
   assign bus_err_o    = err_q;
   assign misaligned_o = mis_q;

endmodule

// File: tb/tb_dbus_wb_master.sv
// Randomized self-checking bench for dbus_wb_master against a transaction-level model.
module tb_dbus_wb_master;

   localparam int TO = 8;
   localparam int M_ACK = 0, M_ERR = 1, M_BOTH = 2, M_NONE = 3;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
   logic        mem_read_i, mem_write_i;
   logic [2:0]  mem_op_i;
   logic        mem_ack_o, stall_o, bus_err_o, misaligned_o;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic        wb_ack_i, wb_err_i;

   int total = 0;
   int bad   = 0;

   dbus_wb_master #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .mem_addr_i   (mem_addr_i),
      .mem_wdata_i  (mem_wdata_i),
      .mem_read_i   (mem_read_i),
      .mem_write_i  (mem_write_i),
      .mem_op_i     (mem_op_i),
      .mem_rdata_o  (mem_rdata_o),
      .mem_ack_o    (mem_ack_o),
      .stall_o      (stall_o),
      .bus_err_o    (bus_err_o),
      .misaligned_o (misaligned_o),
      .wb_cyc_o     (wb_cyc_o),
      .wb_stb_o     (wb_stb_o),
      .wb_we_o      (wb_we_o),
      .wb_adr_o     (wb_adr_o),
      .wb_dat_o     (wb_dat_o),
      .wb_sel_o     (wb_sel_o),
      .wb_dat_i     (wb_dat_i),
      .wb_ack_i     (wb_ack_i),
      .wb_err_i     (wb_err_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One core access; called at a negedge, returns at a negedge with the request dropped.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic rd, input logic wr, input int mode, input int delay,
                                input logic [31:0] sdata);
      int size, off, sel_int, k, stall_cnt, ack_cnt, stray, stbmis, post, exp_req;
      logic undef, mis, bus, first, exp_err, err_seen, mis_seen, we_seen;
      logic [31:0] exp_dat, exp_rdata, mask, v, rdata_seen, adr_seen, dat_seen;
      logic [3:0]  sel_seen;

      undef   = (op == 3'd3) || (op == 3'd6) || (op == 3'd7);
      size    = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
      off     = int'(addr[1:0]);
      mis     = !undef && ((off % size) != 0);
      bus     = !undef && !mis;
      sel_int = ((1 << size) - 1) << off;
      exp_dat = (size == 1) ? 32'(wdata[7:0]) * 32'h01010101 :
                (size == 2) ? 32'(wdata[15:0]) * 32'h00010001 : wdata;
      exp_err = undef || (bus && mode != M_ACK);
      exp_req = !bus ? 0 : (mode == M_NONE) ? TO : delay + 1;
      exp_rdata = 32'd0;
      if (bus && mode == M_ACK && !wr) begin
         mask = (size == 4) ? 32'hFFFFFFFF : 32'((64'd1 << (8 * size)) - 64'd1);
         v = (sdata >> (8 * off)) & mask;
         if (!op[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
         exp_rdata = v;
      end

      mem_op_i = op; mem_addr_i = addr; mem_wdata_i = wdata;
      mem_read_i = rd; mem_write_i = wr; wb_dat_i = sdata;
      k = 0; stall_cnt = 0; ack_cnt = 0; stray = 0; stbmis = 0; post = 0; first = 1'b1;
      rdata_seen = 32'hX; err_seen = 1'bX; mis_seen = 1'bX;
      adr_seen = 32'd0; dat_seen = 32'd0; sel_seen = 4'd0; we_seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (wb_cyc_o !== wb_stb_o) stbmis++;
         if (wb_cyc_o === 1'b1) begin
            if (first) begin
               adr_seen = wb_adr_o; dat_seen = wb_dat_o; sel_seen = wb_sel_o; we_seen = wb_we_o;
               first = 1'b0;
            end
            wb_ack_i = (k == delay) && (mode == M_ACK || mode == M_BOTH);
            wb_err_i = (k == delay) && (mode == M_ERR || mode == M_BOTH);
            k++;
         end else begin
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
         end
         #1;
         if (stall_o === 1'b1) stall_cnt++;
         if (mem_ack_o === 1'b1) begin
            ack_cnt++;
            rdata_seen = mem_rdata_o; err_seen = bus_err_o; mis_seen = misaligned_o;
         end else if (bus_err_o !== 1'b0 || misaligned_o !== 1'b0) begin
            stray++;
         end
         @(negedge clk_i);
         if (ack_cnt > 0) begin
            mem_read_i = 1'b0; mem_write_i = 1'b0;
            post++;
            if (post == 3) break;
         end
      end
      wb_ack_i = 1'b0; wb_err_i = 1'b0;

      checkOutput("ack_count", 32'(ack_cnt), 32'd1);
      checkOutput("stall_cycles", 32'(stall_cnt), 32'(1 + exp_req));
      checkOutput("cyc_cycles", 32'(k), 32'(exp_req));
      checkOutput("cyc_eq_stb", 32'(stbmis), 32'd0);
      checkOutput("stray_flag", 32'(stray), 32'd0);
      checkOutput("rdata", rdata_seen, exp_rdata);
      checkOutput("bus_err", 32'(err_seen), 32'(exp_err));
      checkOutput("misaligned", 32'(mis_seen), 32'(mis));
      if (bus) begin
         checkOutput("wb_adr", adr_seen, {addr[31:2], 2'b00});
         checkOutput("wb_sel", 32'(sel_seen), 32'(sel_int[3:0]));
         checkOutput("wb_we", 32'(we_seen), 32'(wr));
         if (wr) checkOutput("wb_dat", dat_seen, exp_dat);
      end
   endtask

   initial begin
      logic [2:0] rop;
      logic [1:0] rw;
      int rmode;

      reset_i = 1'b1;
      mem_addr_i = 32'd0; mem_wdata_i = 32'd0; mem_read_i = 1'b0; mem_write_i = 1'b0;
      mem_op_i = 3'd0; wb_dat_i = 32'd0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
      repeat (2) @(negedge clk_i);
      checkOutput("rst_cyc", 32'(wb_cyc_o), 32'd0);
      checkOutput("rst_stb", 32'(wb_stb_o), 32'd0);
      checkOutput("rst_adr", wb_adr_o, 32'd0);
      checkOutput("rst_dat", wb_dat_o, 32'd0);
      checkOutput("rst_sel", 32'(wb_sel_o), 32'd0);
      checkOutput("rst_rdata", mem_rdata_o, 32'd0);
      checkOutput("rst_flags", {28'd0, mem_ack_o, bus_err_o, misaligned_o, stall_o}, 32'd0);
      reset_i = 1'b0;
      @(negedge clk_i);

      $display("[TB] directed cases");
      applyStimulus(3'b010, 32'h100, 32'hDEADBEEF, 1'b0, 1'b1, M_ACK, 1, 32'd0);
      applyStimulus(3'b000, 32'h103, 32'd0, 1'b1, 1'b0, M_ACK, 0, 32'h80FF0000);
      applyStimulus(3'b100, 32'h103, 32'd0, 1'b1, 1'b0, M_ACK, 0, 32'h80FF0000);
      applyStimulus(3'b001, 32'h101, 32'd0, 1'b1, 1'b0, M_ACK, 0, 32'h12345678);
      applyStimulus(3'b010, 32'h200, 32'd0, 1'b1, 1'b0, M_NONE, 0, 32'h12345678);
      applyStimulus(3'b010, 32'h204, 32'd0, 1'b1, 1'b0, M_BOTH, 2, 32'hCAFEF00D);
      applyStimulus(3'b110, 32'h208, 32'd0, 1'b1, 1'b0, M_ACK, 0, 32'h0);
      applyStimulus(3'b101, 32'h20A, 32'd0, 1'b1, 1'b1, M_ACK, 0, 32'h8001FFFF);

      // Reset in the middle of a bus cycle must drop cyc at once and never acknowledge.
      mem_op_i = 3'b010; mem_addr_i = 32'h300; mem_read_i = 1'b1; mem_write_i = 1'b0;
      repeat (3) @(negedge clk_i);
      checkOutput("pre_rst_cyc", 32'(wb_cyc_o), 32'd1);
      #2 reset_i = 1'b1;
      #1;
      checkOutput("mid_rst_cyc", 32'(wb_cyc_o), 32'd0);
      checkOutput("mid_rst_stb", 32'(wb_stb_o), 32'd0);
      checkOutput("mid_rst_adr", wb_adr_o, 32'd0);
      checkOutput("mid_rst_ack", 32'(mem_ack_o), 32'd0);
      checkOutput("mid_rst_stall", 32'(stall_o), 32'd1);
      @(negedge clk_i);
      mem_read_i = 1'b0;
      reset_i = 1'b0;
      begin
         int acks = 0;
         for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            if (mem_ack_o !== 1'b0 || wb_cyc_o !== 1'b0) acks++;
         end
         checkOutput("post_rst_quiet", 32'(acks), 32'd0);
      end
      applyStimulus(3'b010, 32'h304, 32'd0, 1'b1, 1'b0, M_NONE, 0, 32'h0);

      $display("[TB] random cases");
      for (int t = 0; t < 40; t++) begin
         rop = 3'($urandom_range(0, 7));
         rw = 2'($urandom_range(1, 3));
         rmode = ($urandom_range(0, 5) == 0) ? M_NONE : int'($urandom_range(0, 2));
         applyStimulus(rop, $urandom, $urandom, rw[0], rw[1], rmode,
                       int'($urandom_range(0, 3)), $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
